// File: rtl/paddle_centroid_tracker.sv
// Per-frame colour statistics and integer centroid calculation for two paddle colours.
// Optional bounding-box tracking is built when PADDLE_BBOX_EN is defined.
module paddle_centroid_tracker #(
  parameter int unsigned MIN_PIXELS = 16,
  parameter int unsigned FRAME_W    = 640,
  parameter int unsigned FRAME_H    = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [10:0] row,
  input  logic [11:0] col,
  input  logic [1:0]  color_enc,
  input  logic        color_valid,
  output logic        result_valid,
  output logic        found1,
  output logic        found2,
  output logic [11:0] cent1_x,
  output logic [11:0] cent2_x,
  output logic [10:0] cent1_y,
  output logic [10:0] cent2_y,
  output logic [18:0] count1,
  output logic [18:0] count2,
  output logic [11:0] bbox1_min_x,
  output logic [11:0] bbox1_max_x,
  output logic [11:0] bbox2_min_x,
  output logic [11:0] bbox2_max_x,
  output logic [10:0] bbox1_min_y,
  output logic [10:0] bbox1_max_y,
  output logic [10:0] bbox2_min_y,
  output logic [10:0] bbox2_max_y,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned CW    = 19;
  localparam int unsigned SW    = 28;
  localparam int unsigned XW    = 12;
  localparam int unsigned YW    = 11;
  localparam int unsigned BW    = 5;
  localparam int unsigned STEPS = 28;

  typedef enum logic [1:0] {ST_ACCUM, ST_DIV, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q [2], cnt_d [2], cnt_acc [2];
  logic [SW-1:0] sx_q [2], sx_d [2], sx_acc [2];
  logic [SW-1:0] sy_q [2], sy_d [2], sy_acc [2];
  logic [CW-1:0] snap_cnt_q [2], snap_cnt_d [2];
  logic [SW-1:0] snap_sx_q [2], snap_sx_d [2];
  logic [SW-1:0] snap_sy_q [2], snap_sy_d [2];
  logic [1:0]    sel_q, sel_d;
  logic [BW-1:0] step_q, step_d;
  logic [SW-1:0] dvd_q, dvd_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [XW-1:0] qx_q [2], qx_d [2];
  logic [YW-1:0] qy_q [2], qy_d [2];
  logic          found_q [2], found_d [2];
  logic [CW-1:0] ocnt_q [2], ocnt_d [2];
  logic [XW-1:0] cx_q [2], cx_d [2];
  logic [YW-1:0] cy_q [2], cy_d [2];
  logic          busy_q, busy_d, rv_q, rv_d, ovr_q, ovr_d;

  logic          hit [2];
  logic          found_snap [2];
  logic          eof, div_c, qbit;
  logic [CW-1:0] divisor, rem_src, rem_nxt;
  logic [SW-1:0] dvd_src, dvd_nxt;
  logic [CW:0]   rem_sh;

`ifdef PADDLE_BBOX_EN
  logic [XW-1:0] minx_q [2], minx_d [2], minx_acc [2], maxx_q [2], maxx_d [2], maxx_acc [2];
  logic [YW-1:0] miny_q [2], miny_d [2], miny_acc [2], maxy_q [2], maxy_d [2], maxy_acc [2];
  logic [XW-1:0] s_minx_q [2], s_minx_d [2], s_maxx_q [2], s_maxx_d [2];
  logic [YW-1:0] s_miny_q [2], s_miny_d [2], s_maxy_q [2], s_maxy_d [2];
  logic [XW-1:0] o_minx_q [2], o_minx_d [2], o_maxx_q [2], o_maxx_d [2];
  logic [YW-1:0] o_miny_q [2], o_miny_d [2], o_maxy_q [2], o_maxy_d [2];
`endif

  assign eof = pixel_valid && (row == YW'(FRAME_H - 1)) && (col == XW'(FRAME_W - 1));
  assign hit[0] = pixel_valid && color_valid && (color_enc == 2'b01);
  assign hit[1] = pixel_valid && color_valid && (color_enc == 2'b10);

  // Running accumulators including the current pixel's contribution
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cnt_acc[c] = cnt_q[c] + CW'(hit[c]);
      sx_acc[c]  = sx_q[c] + (hit[c] ? SW'(col) : '0);
      sy_acc[c]  = sy_q[c] + (hit[c] ? SW'(row) : '0);
      found_snap[c] = (snap_cnt_q[c] >= CW'(MIN_PIXELS));
`ifdef PADDLE_BBOX_EN
      minx_acc[c] = (hit[c] && (col < minx_q[c])) ? col : minx_q[c];
      maxx_acc[c] = (hit[c] && (col > maxx_q[c])) ? col : maxx_q[c];
      miny_acc[c] = (hit[c] && (row < miny_q[c])) ? row : miny_q[c];
      maxy_acc[c] = (hit[c] && (row > maxy_q[c])) ? row : maxy_q[c];
`endif
    end
  end

  // Restoring divider datapath; step 0 loads the next dividend from the snapshot
  always_comb begin
    div_c   = sel_q[1];
    divisor = found_snap[div_c] ? snap_cnt_q[div_c] : CW'(1);
    dvd_src = (step_q == '0) ? (sel_q[0] ? snap_sy_q[div_c] : snap_sx_q[div_c]) : dvd_q;
    rem_src = (step_q == '0) ? '0 : rem_q;
    rem_sh  = {rem_src, dvd_src[SW-1]};
    qbit    = (rem_sh >= {1'b0, divisor});
    rem_nxt = qbit ? CW'(rem_sh - {1'b0, divisor}) : rem_sh[CW-1:0];
    dvd_nxt = {dvd_src[SW-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sel_d   = sel_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    for (int c = 0; c < 2; c++) begin
      cnt_d[c]      = eof ? '0 : cnt_acc[c];
      sx_d[c]       = eof ? '0 : sx_acc[c];
      sy_d[c]       = eof ? '0 : sy_acc[c];
      snap_cnt_d[c] = snap_cnt_q[c];
      snap_sx_d[c]  = snap_sx_q[c];
      snap_sy_d[c]  = snap_sy_q[c];
      qx_d[c]       = qx_q[c];
      qy_d[c]       = qy_q[c];
      found_d[c]    = found_q[c];
      ocnt_d[c]     = ocnt_q[c];
      cx_d[c]       = cx_q[c];
      cy_d[c]       = cy_q[c];
`ifdef PADDLE_BBOX_EN
      minx_d[c]   = eof ? '1 : minx_acc[c];
      maxx_d[c]   = eof ? '0 : maxx_acc[c];
      miny_d[c]   = eof ? '1 : miny_acc[c];
      maxy_d[c]   = eof ? '0 : maxy_acc[c];
      s_minx_d[c] = s_minx_q[c];
      s_maxx_d[c] = s_maxx_q[c];
      s_miny_d[c] = s_miny_q[c];
      s_maxy_d[c] = s_maxy_q[c];
      o_minx_d[c] = o_minx_q[c];
      o_maxx_d[c] = o_maxx_q[c];
      o_miny_d[c] = o_miny_q[c];
      o_maxy_d[c] = o_maxy_q[c];
`endif
    end
    case (state_q)
      ST_ACCUM: begin
        if (eof) begin
          state_d = ST_DIV;
          step_d  = '0;
          sel_d   = '0;
          for (int c = 0; c < 2; c++) begin
            snap_cnt_d[c] = cnt_acc[c];
            snap_sx_d[c]  = sx_acc[c];
            snap_sy_d[c]  = sy_acc[c];
`ifdef PADDLE_BBOX_EN
            s_minx_d[c] = minx_acc[c];
            s_maxx_d[c] = maxx_acc[c];
            s_miny_d[c] = miny_acc[c];
            s_maxy_d[c] = maxy_acc[c];
`endif
          end
        end
      end
      ST_DIV: begin
        dvd_d  = dvd_nxt;
        rem_d  = rem_nxt;
        step_d = step_q + BW'(1);
        if (step_q == BW'(STEPS - 1)) begin
          step_d = '0;
          if (sel_q[0]) qy_d[div_c] = dvd_nxt[YW-1:0];
          else          qx_d[div_c] = dvd_nxt[XW-1:0];
          if (sel_q == 2'd3) state_d = ST_DONE;
          else               sel_d   = sel_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_ACCUM;
        for (int c = 0; c < 2; c++) begin
          found_d[c] = found_snap[c];
          ocnt_d[c]  = snap_cnt_q[c];
          cx_d[c]    = found_snap[c] ? qx_q[c] : '0;
          cy_d[c]    = found_snap[c] ? qy_q[c] : '0;
`ifdef PADDLE_BBOX_EN
          o_minx_d[c] = found_snap[c] ? s_minx_q[c] : '0;
          o_maxx_d[c] = found_snap[c] ? s_maxx_q[c] : '0;
          o_miny_d[c] = found_snap[c] ? s_miny_q[c] : '0;
          o_maxy_d[c] = found_snap[c] ? s_maxy_q[c] : '0;
`endif
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    busy_d = (state_d != ST_ACCUM);
    rv_d   = (state_q == ST_DONE);
    ovr_d  = eof && (state_q != ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      step_q  <= '0;
      sel_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        cnt_q[c]      <= '0;
        sx_q[c]       <= '0;
        sy_q[c]       <= '0;
        snap_cnt_q[c] <= '0;
        snap_sx_q[c]  <= '0;
        snap_sy_q[c]  <= '0;
        qx_q[c]       <= '0;
        qy_q[c]       <= '0;
        found_q[c]    <= 1'b0;
        ocnt_q[c]     <= '0;
        cx_q[c]       <= '0;
        cy_q[c]       <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sel_q   <= sel_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      ovr_q   <= ovr_d;
      for (int c = 0; c < 2; c++) begin
        cnt_q[c]      <= cnt_d[c];
        sx_q[c]       <= sx_d[c];
        sy_q[c]       <= sy_d[c];
        snap_cnt_q[c] <= snap_cnt_d[c];
        snap_sx_q[c]  <= snap_sx_d[c];
        snap_sy_q[c]  <= snap_sy_d[c];
        qx_q[c]       <= qx_d[c];
        qy_q[c]       <= qy_d[c];
        found_q[c]    <= found_d[c];
        ocnt_q[c]     <= ocnt_d[c];
        cx_q[c]       <= cx_d[c];
        cy_q[c]       <= cy_d[c];
      end
    end
  end

`ifdef PADDLE_BBOX_EN
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        minx_q[c]   <= '1;
        maxx_q[c]   <= '0;
        miny_q[c]   <= '1;
        maxy_q[c]   <= '0;
        s_minx_q[c] <= '0;
        s_maxx_q[c] <= '0;
        s_miny_q[c] <= '0;
        s_maxy_q[c] <= '0;
        o_minx_q[c] <= '0;
        o_maxx_q[c] <= '0;
        o_miny_q[c] <= '0;
        o_maxy_q[c] <= '0;
      end else begin
        minx_q[c]   <= minx_d[c];
        maxx_q[c]   <= maxx_d[c];
        miny_q[c]   <= miny_d[c];
        maxy_q[c]   <= maxy_d[c];
        s_minx_q[c] <= s_minx_d[c];
        s_maxx_q[c] <= s_maxx_d[c];
        s_miny_q[c] <= s_miny_d[c];
        s_maxy_q[c] <= s_maxy_d[c];
        o_minx_q[c] <= o_minx_d[c];
        o_maxx_q[c] <= o_maxx_d[c];
        o_miny_q[c] <= o_miny_d[c];
        o_maxy_q[c] <= o_maxy_d[c];
      end
    end
  end

  assign bbox1_min_x = o_minx_q[0];
  assign bbox1_max_x = o_maxx_q[0];
  assign bbox2_min_x = o_minx_q[1];
  assign bbox2_max_x = o_maxx_q[1];
  assign bbox1_min_y = o_miny_q[0];
  assign bbox1_max_y = o_maxy_q[0];
  assign bbox2_min_y = o_miny_q[1];
  assign bbox2_max_y = o_maxy_q[1];
`else
  assign bbox1_min_x = '0;
  assign bbox1_max_x = '0;
  assign bbox2_min_x = '0;
  assign bbox2_max_x = '0;
  assign bbox1_min_y = '0;
  assign bbox1_max_y = '0;
  assign bbox2_min_y = '0;
  assign bbox2_max_y = '0;
`endif

  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;
  assign found1       = found_q[0];
  assign found2       = found_q[1];
  assign count1       = ocnt_q[0];
  assign count2       = ocnt_q[1];
  assign cent1_x      = cx_q[0];
  assign cent2_x      = cx_q[1];
  assign cent1_y      = cy_q[0];
  assign cent2_y      = cy_q[1];

endmodule

// File: tb/tb_paddle_centroid_tracker.sv
// Scoreboard bench for paddle_centroid_tracker: directed frames, expected results queued
// at EOF and checked by an independent monitor on each result_valid strobe.
module tb_paddle_centroid_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_valid;
  logic [10:0] row;
  logic [11:0] col;
  logic [1:0]  color_enc;
  logic        color_valid;
  logic        result_valid, found1, found2, busy, overrun;
  logic [11:0] cent1_x, cent2_x, bbox1_min_x, bbox1_max_x, bbox2_min_x, bbox2_max_x;
  logic [10:0] cent1_y, cent2_y, bbox1_min_y, bbox1_max_y, bbox2_min_y, bbox2_max_y;
  logic [18:0] count1, count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic f;
    int   n, cx, cy, bx0, by0, bx1, by1;
  } col_t;

  col_t q1[$];
  col_t q2[$];

  paddle_centroid_tracker dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .row(row), .col(col),
    .color_enc(color_enc), .color_valid(color_valid), .result_valid(result_valid),
    .found1(found1), .found2(found2), .cent1_x(cent1_x), .cent2_x(cent2_x),
    .cent1_y(cent1_y), .cent2_y(cent2_y), .count1(count1), .count2(count2),
    .bbox1_min_x(bbox1_min_x), .bbox1_max_x(bbox1_max_x),
    .bbox2_min_x(bbox2_min_x), .bbox2_max_x(bbox2_max_x),
    .bbox1_min_y(bbox1_min_y), .bbox1_max_y(bbox1_max_y),
    .bbox2_min_y(bbox2_min_y), .bbox2_max_y(bbox2_max_y),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic col_t mk(input logic f, input int n, cx, cy, bx0, by0, bx1, by1);
    col_t e;
    e.f = f; e.n = n;
    e.cx = f ? cx : 0;
    e.cy = f ? cy : 0;
`ifdef PADDLE_BBOX_EN
    e.bx0 = f ? bx0 : 0; e.by0 = f ? by0 : 0; e.bx1 = f ? bx1 : 0; e.by1 = f ? by1 : 0;
`else
    e.bx0 = 0; e.by0 = 0; e.bx1 = 0; e.by1 = 0;
`endif
    return e;
  endfunction

  task automatic cmp_col(input string t, input logic f, input logic [18:0] n,
                         input logic [11:0] cx, input logic [10:0] cy,
                         input logic [11:0] bx0, input logic [10:0] by0,
                         input logic [11:0] bx1, input logic [10:0] by1, input col_t e);
    chk({t, ".found"}, 32'(f), 32'(e.f));
    chk({t, ".count"}, 32'(n), e.n);
    chk({t, ".cent_x"}, 32'(cx), e.cx);
    chk({t, ".cent_y"}, 32'(cy), e.cy);
    chk({t, ".bbox_min_x"}, 32'(bx0), e.bx0);
    chk({t, ".bbox_min_y"}, 32'(by0), e.by0);
    chk({t, ".bbox_max_x"}, 32'(bx1), e.bx1);
    chk({t, ".bbox_max_y"}, 32'(by1), e.by1);
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (result_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid: got 1 expected 0 (no result pending)");
      end else begin
        col_t e1, e2;
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        cmp_col("c1", found1, count1, cent1_x, cent1_y, bbox1_min_x, bbox1_min_y,
                bbox1_max_x, bbox1_max_y, e1);
        cmp_col("c2", found2, count2, cent2_x, cent2_y, bbox2_min_x, bbox2_min_y,
                bbox2_max_x, bbox2_max_y, e2);
      end
    end
  end

  task automatic pix(input int r, input int c, input logic [1:0] e, input logic cv);
    pixel_valid = 1'b1; row = 11'(r); col = 12'(c); color_enc = e; color_valid = cv;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    pixel_valid = 1'b0; color_valid = 1'b0; color_enc = 2'b00; row = '0; col = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input col_t e1, input col_t e2);
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q1.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, ".result_seen"}, 32'(q1.size()), 0);
    idle(2);
  endtask

  task automatic square1();
    for (int r = 200; r < 210; r++)
      for (int c = 100; c < 110; c++) pix(r, c, 2'b01, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  busy_ok;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);

    chk("rst.result_valid", 32'(result_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.overrun", 32'(overrun), 0);
    chk("rst.found1", 32'(found1), 0);
    chk("rst.count2", 32'(count2), 0);
    chk("rst.cent1_x", 32'(cent1_x), 0);

    // Colour-1 10x10 square
    square1();
    expect_frame(mk(1, 100, 104, 204, 100, 200, 109, 209), mk(0, 0, 0, 0, 0, 0, 0, 0));
    pix(479, 639, 2'b00, 1'b1);
    idle(1);
    wait_drain("sq");

    // Colour 2 below threshold
    for (int c = 300; c < 310; c++) pix(50, c, 2'b10, 1'b1);
    expect_frame(mk(0, 0, 0, 0, 0, 0, 0, 0), mk(0, 10, 0, 0, 0, 0, 0, 0));
    pix(479, 639, 2'b00, 1'b1);
    idle(1);
    wait_drain("few");

    // EOF pixel itself counted, fixed latency
    for (int c = 624; c < 639; c++) pix(479, c, 2'b01, 1'b1);
    expect_frame(mk(1, 16, 631, 479, 624, 479, 639, 479), mk(0, 0, 0, 0, 0, 0, 0, 0));
    pix(479, 639, 2'b01, 1'b1);
    pixel_valid = 1'b0; color_valid = 1'b0;
    chk("lat.busy_rise", 32'(busy), 1);
    n = 0;
    busy_ok = 1'b1;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (result_valid) break;
      if (!busy) busy_ok = 1'b0;
    end
    chk("lat.latency", n, 113);
    chk("lat.busy_window", 32'(busy_ok), 1);
    chk("lat.busy_fall", 32'(busy), 0);
    @(posedge clk);
    #1;
    chk("lat.strobe_width", 32'(result_valid), 0);
    @(negedge clk);
    wait_drain("lat");

    // Consecutive frames, no carry-over
    repeat (20) pix(10, 10, 2'b01, 1'b1);
    expect_frame(mk(1, 20, 10, 10, 10, 10, 10, 10), mk(0, 0, 0, 0, 0, 0, 0, 0));
    pix(479, 639, 2'b00, 1'b1);
    idle(1);
    wait_drain("fa");
    repeat (20) pix(400, 600, 2'b01, 1'b1);
    expect_frame(mk(1, 20, 600, 400, 600, 400, 600, 400), mk(0, 0, 0, 0, 0, 0, 0, 0));
    pix(479, 639, 2'b00, 1'b1);
    idle(1);
    wait_drain("fb");

    // Reset in the middle of a division aborts the frame
    square1();
    pix(479, 639, 2'b00, 1'b1);
    pixel_valid = 1'b0; color_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.found1", 32'(found1), 0);
    chk("abort.count1", 32'(count1), 0);
    chk("abort.cent1_x", 32'(cent1_x), 0);
    chk("abort.cent1_y", 32'(cent1_y), 0);
    @(negedge clk);
    idle(150);
    square1();
    expect_frame(mk(1, 100, 104, 204, 100, 200, 109, 209), mk(0, 0, 0, 0, 0, 0, 0, 0));
    pix(479, 639, 2'b00, 1'b1);
    idle(1);
    wait_drain("post_abort");

    // Ambiguous / invalid colours ignored; EOF while busy raises overrun
    for (int c = 0; c < 40; c++) pix(10, c, 2'b11, 1'b1);
    for (int c = 0; c < 40; c++) pix(11, c, 2'b01, 1'b0);
    expect_frame(mk(0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 0));
    pix(479, 639, 2'b00, 1'b1);
    chk("ovr.quiet", 32'(overrun), 0);
    idle(5);
    pix(479, 639, 2'b00, 1'b1);
    pixel_valid = 1'b0; color_valid = 1'b0;
    chk("ovr.pulse", 32'(overrun), 1);
    chk("ovr.busy", 32'(busy), 1);
    @(negedge clk);
    chk("ovr.width", 32'(overrun), 0);
    wait_drain("ovr");

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
